// File: rtl/matmul_operand_loader_if.sv
// Handshake and operand bus between the pad-side feeder, the loader and the matmul core.
// The loader uses the slave modport; the upstream/core side uses master.
interface matmul_operand_loader_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              abort;
  logic [N*N*DW-1:0] a_flat;
  logic [N*N*DW-1:0] b_flat;
  logic              core_start;
  logic              core_done;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_data, abort, core_done,
    input  in_ready, a_flat, b_flat, core_start, busy, err
  );

  modport slave (
    input  in_valid, in_data, abort, core_done,
    output in_ready, a_flat, b_flat, core_start, busy, err
  );
endinterface

// File: rtl/matmul_operand_loader.sv
// Deserialises a byte stream into operand matrices A then B, pulses core_start and holds the
// operands until core_done. Optional trailing checksum beat via `define LOADER_CHECKSUM_EN.
module matmul_operand_loader #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  matmul_operand_loader_if.slave  bus
);

  localparam int NE   = N * N;
  localparam int CW   = (NE > 1) ? $clog2(NE) : 1;
  localparam int LAST = NE - 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LOAD_A, LOAD_B, CHK, START, WAIT} state_t;
`else
  typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT} state_t;
`endif

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [NE*DW-1:0]   a_q, b_q;
  logic               in_ready, core_start, busy;
  logic               accept, last_beat;

  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (count == CW'(LAST));

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic          err_q;
  logic          sum_ok;

  assign sum_ok = (bus.in_data == sum_q);
`endif

  // State register: abort behaves like a soft restart of the load sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || bus.abort) state <= LOAD_A;
    else                  state <= state_next;
  end

  // Next-state decode; abort is applied in the register above.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps partial case paths from inferring latches.
    state_next = state;
    unique case (state)
      LOAD_A: if (accept && last_beat) state_next = LOAD_B;
`ifdef LOADER_CHECKSUM_EN
      LOAD_B: if (accept && last_beat) state_next = CHK;
      CHK:    if (accept)              state_next = sum_ok ? START : LOAD_A;
`else
      LOAD_B: if (accept && last_beat) state_next = START;
`endif
      START:  state_next = WAIT;
      WAIT:   if (bus.core_done)       state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // Outputs are pure decodes of the current state.
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;
    unique case (state)
      LOAD_A, LOAD_B: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:            in_ready = 1'b1;
`endif
      START: begin
        core_start = 1'b1;
        busy       = 1'b1;
      end
      WAIT:           busy     = 1'b1;
      default: ;
    endcase
  end

  // Beat counter only advances on accepted operand beats and wraps at each matrix boundary.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      count <= '0;
    end else if (accept && (state == LOAD_A || state == LOAD_B)) begin
      count <= last_beat ? '0 : count + 1'b1;
    end
  end

  // Operand registers survive abort and operand-set boundaries; only written elements change.
  always_ff @(posedge clk) begin
    // NOTE: these operand arrays are reset on purpose because their zero value is architecturally visible.
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (!bus.abort && accept) begin
      if (state == LOAD_A) a_q[count*DW +: DW] <= bus.in_data;
      if (state == LOAD_B) b_q[count*DW +: DW] <= bus.in_data;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum restarts whenever a fresh A load begins, including after abort.
  always_ff @(posedge clk) begin
    if (rst || bus.abort || (state != LOAD_A && state_next == LOAD_A)) begin
      sum_q <= '0;
    end else if (accept && (state == LOAD_A || state == LOAD_B)) begin
      sum_q <= sum_q + bus.in_data;
    end
  end

  // Sticky until rst; abort leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst)                                                     err_q <= 1'b0;
    else if (!bus.abort && accept && state == CHK && !sum_ok)    err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.core_start = core_start;
  assign bus.busy       = busy;
  assign bus.a_flat     = a_q;
  assign bus.b_flat     = b_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Scoreboard bench for matmul_operand_loader (N=2, DW=8): expected operand sets are queued at
// stimulus time and popped by a monitor on every core_start pulse.
module tb_matmul_operand_loader;

  localparam int N  = 2;
  localparam int DW = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } ops_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matmul_operand_loader_if #(.N(N), .DW(DW)) bus ();

  matmul_operand_loader #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   start_count  = 0;
  ops_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the oldest queued operand set.
  initial begin
    ops_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.core_start === 1'b1) begin
        start_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_core_start", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_a_flat", bus.a_flat, e.a);
          check("sb_b_flat", bus.b_flat, e.b);
          check("sb_busy_on_start", bus.busy, 1);
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("beat_accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send_set(input logic [7:0] first, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_beat(first + 8'(i));
      if (gap > 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask

  task automatic release_core();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int budget;
    budget = 0;
    while (bus.busy !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check(name, bus.busy, 1);
  endtask

  initial begin
    int ready_hi;
    int starts0;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.core_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_flat", bus.a_flat, 0);
    check("rst_b_flat", bus.b_flat, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // Test 1: back-to-back load, start latency
    sb_q.push_back('{a: 32'h04030201, b: 32'h08070605});
    send_set(8'h01, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t1_start_latency", bus.core_start, 1);
    check("t1_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    check("t1_start_one_cycle", bus.core_start, 0);
    check("t1_busy_wait", bus.busy, 1);

    // Test 2: hold in WAIT with junk beats offered
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    ready_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) ready_hi++;
    end
    check("t2_in_ready_held_low", ready_hi, 0);
    check("t2_a_hold", bus.a_flat, 32'h04030201);
    check("t2_b_hold", bus.b_flat, 32'h08070605);
    check("t2_start_count", start_count, 1);
    release_core();
    check("t2_ready_after_done", bus.in_ready, 1);
    check("t2_busy_after_done", bus.busy, 0);

    // core_done outside WAIT is ignored
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    check("t2_done_ignored_ready", bus.in_ready, 1);
    check("t2_done_ignored_busy", bus.busy, 0);

    // Test 3: one valid every three cycles
    sb_q.push_back('{a: 32'h04030201, b: 32'h08070605});
    send_set(8'h01, 2);
    wait_busy("t3_reached_wait");
    check("t3_start_count", start_count, 2);
    release_core();

    // Test 4: abort after 5 beats, with a beat offered in the abort cycle
    for (int i = 0; i < 5; i++) send_beat(8'hA0 + 8'(i));
    @(negedge clk);
    bus.abort    = 1'b1;
    bus.in_data  = 8'hEE;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_abort_a", bus.a_flat, 32'hA3A2A1A0);
    check("t4_abort_b", bus.b_flat, 32'h080706A4);
    check("t4_abort_ready", bus.in_ready, 1);
    check("t4_abort_busy", bus.busy, 0);
    starts0 = start_count;
    sb_q.push_back('{a: 32'h13121110, b: 32'h17161514});
    send_set(8'h10, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_one_start", start_count - starts0, 1);
    release_core();

    // Test 5: rst in WAIT
    sb_q.push_back('{a: 32'h24232221, b: 32'h28272625});
    send_set(8'h21, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_busy("t5_reached_wait");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_a", bus.a_flat, 0);
    check("t5_rst_b", bus.b_flat, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_start", bus.core_start, 0);
    check("t5_rst_ready", bus.in_ready, 1);
    check("t5_rst_err", bus.err, 0);
    starts0 = start_count;
    release_core();
    @(negedge clk);
    check("t5_done_no_effect_busy", bus.busy, 0);
    check("t5_done_no_effect_ready", bus.in_ready, 1);
    check("t5_done_no_start", start_count - starts0, 0);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: good checksum (0x24), then bad checksum (0x25)
    sb_q.push_back('{a: 32'h04030201, b: 32'h08070605});
    send_set(8'h01, 0);
    send_beat(8'h24);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t6_good_start", bus.core_start, 1);
    check("t6_good_err", bus.err, 0);
    release_core();
    starts0 = start_count;
    send_set(8'h01, 0);
    send_beat(8'h25);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_bad_no_start", start_count - starts0, 0);
    check("t6_bad_err", bus.err, 1);
    check("t6_bad_busy", bus.busy, 0);
    send_beat(8'h55);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t6_bad_back_in_load_a", bus.a_flat, 32'h04030255);
    check("t6_err_sticky", bus.err, 1);
`else
    check("err_tied_low", bus.err, 0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
